// File: rtl/codec_pkg.sv
// codec_pkg: WM8731 constants and the write-FSM state encoding, shared by
// codec register writers.
//   DEV_ADDR     - codec 7-bit I2C address (CSB low)
//   REG_HP_OUT   - left headphone-out register address
//   LRHPBOTH_BIT - position of LRHPBOTH inside the 9-bit register data word
//   wr_state_e   - frame sequencer states
package codec_pkg;

  localparam logic [6:0] DEV_ADDR     = 7'h1A;
  localparam logic [6:0] REG_HP_OUT   = 7'h02;
  localparam int         LRHPBOTH_BIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: one-cycle strobe every CLK_DIV enabled clocks (one I2C
// quarter-bit).
//   clk, rst_n - clock, synchronous active-low reset
//   en         - count while high
//   clr        - restart the count at 0 (wins over en)
//   tick       - high in the last cycle of each CLK_DIV-cycle period
module i2c_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr)  cnt <= '0;
    else if (en)        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/codec_volume_writer.sv
// codec_volume_writer: writes the 7-bit headphone volume into the WM8731
// headphone-out register over a write-only, single-master I2C link.
// Requests arriving mid-transfer are coalesced; the latest one is sent next.
//   clk, rst_n  - system clock, synchronous active-low reset
//   volume      - volume code, sampled when vol_update is high
//   vol_update  - one-cycle write request
//   i2c_sclk    - I2C clock, push-pull, idles high
//   i2c_sdat    - I2C data, open-drain (drives 0 or Z)
//   busy        - transfer in progress (launch through DONE)
//   done        - one-cycle pulse at end of each frame
//   nack_err    - sticky NACK flag, cleared by a fully ACKed frame
module codec_volume_writer
  import codec_pkg::*;
#(
  parameter int         CLK_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = codec_pkg::DEV_ADDR,
  parameter logic [6:0] REG_ADDR = REG_HP_OUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] volume,
  input  logic       vol_update,
  output logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic       busy,
  output logic       done,
  output logic       nack_err
);

  // 9-bit register word flags: LRHPBOTH set, zero-cross (bit 7) clear.
  localparam logic [8:0] HP_FLAGS = 9'(1) << LRHPBOTH_BIT;

  wr_state_e  state;
  logic [1:0] q;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] shift;
  logic [6:0] vol_src;
  logic [6:0] pend_vol;
  logic       pend;
  logic       sda_low;
  logic       ack_bit;
  logic [1:0] sda_sync;
  logic       tick;
  logic [1:0] byte_sel;
  logic [7:0] nxt_byte;

  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [6:0] v);
    case (idx)
      2'd0:    frame_byte = {DEV_ADDR, 1'b0};
      2'd1:    frame_byte = {REG_ADDR, HP_FLAGS[8]};
      default: frame_byte = HP_FLAGS[7:0] | {1'b0, v};
    endcase
  endfunction

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != ST_IDLE),
    .clr   (state == ST_IDLE),
    .tick  (tick)
  );

  // Byte to load next: byte0 when leaving START, otherwise the one after byte_cnt.
  always_comb begin
    byte_sel = (state == ST_ACK) ? byte_cnt + 2'd1 : 2'd0;
    nxt_byte = frame_byte(byte_sel, vol_src);
  end

  // SDA is only sampled mid-SCL-high, long after the slave settled it, so a
  // plain two-flop synchroniser is enough.
  always_ff @(posedge clk) begin
    if (!rst_n) sda_sync <= 2'b11;
    else        sda_sync <= {sda_sync[0], i2c_sdat !== 1'b0};
  end

  // Bus outputs are updated on the edge that enters each quarter, so they
  // hold the value of the quarter currently in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      q        <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      vol_src  <= '0;
      pend_vol <= '0;
      pend     <= 1'b0;
      ack_bit  <= 1'b1;
      i2c_sclk <= 1'b1;
      sda_low  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (pend) begin
          state    <= ST_START;
          q        <= '0;
          byte_cnt <= '0;
          vol_src  <= pend_vol;
          pend     <= 1'b0;
          busy     <= 1'b1;
        end
        ST_START: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd1) sda_low <= 1'b1;
          if (q == 2'd3) begin
            state    <= ST_DATA;
            bit_cnt  <= '0;
            shift    <= nxt_byte;
            i2c_sclk <= 1'b0;
            sda_low  <= ~nxt_byte[7];
          end
        end
        ST_DATA: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd1: i2c_sclk <= 1'b1;
            2'd3: begin
              i2c_sclk <= 1'b0;
              if (bit_cnt == 3'd7) begin
                state   <= ST_ACK;
                sda_low <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {shift[6:0], 1'b0};
                sda_low <= ~shift[6];
              end
            end
            default: ;
          endcase
        end
        ST_ACK: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd1: i2c_sclk <= 1'b1;
            2'd2: ack_bit  <= sda_sync[1];
            2'd3: begin
              i2c_sclk <= 1'b0;
              if (!ack_bit && byte_cnt != 2'd2) begin
                state    <= ST_DATA;
                byte_cnt <= byte_cnt + 2'd1;
                bit_cnt  <= '0;
                shift    <= nxt_byte;
                sda_low  <= ~nxt_byte[7];
              end else begin
                // NACK on any byte, or final ACK: finish with STOP.
                state    <= ST_STOP;
                sda_low  <= 1'b1;
                nack_err <= ack_bit;
              end
            end
            default: ;
          endcase
        end
        ST_STOP: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd0: i2c_sclk <= 1'b1;
            2'd1: sda_low  <= 1'b0;
            2'd3: begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // Latest request wins; also overrides the launch clear above.
      if (vol_update) begin
        pend     <= 1'b1;
        pend_vol <= volume;
      end
    end
  end

  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_codec_volume_writer.sv
module tb_codec_volume_writer;

  localparam int CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] volume = '0;
  logic       vol_update = 1'b0;
  logic       i2c_sclk, busy, done, nack_err;
  logic       slave_low = 1'b0;
  wire        sda_line;

  pullup (sda_line);
  assign sda_line = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  codec_volume_writer #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .volume     (volume),
    .vol_update (vol_update),
    .i2c_sclk   (i2c_sclk),
    .i2c_sdat   (sda_line),
    .busy       (busy),
    .done       (done),
    .nack_err   (nack_err)
  );

  typedef struct {
    logic [6:0] vol;
    bit         nack;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  bit         nack_addr = 1'b0;

  // bus decoder state
  logic [7:0] fb[$];
  int         scl_rises = 0;
  bit         started = 1'b0;
  bit         stopped = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus decoder plus ACKing slave, sampled once per system clock.
  initial begin
    bit scl, sda, scl_p, sda_p;
    int bitn;
    logic [7:0] cur;
    scl_p = 1'b1; sda_p = 1'b1; bitn = 0; cur = '0;
    forever begin
      @(negedge clk);
      scl = (i2c_sclk === 1'b1);
      sda = (sda_line !== 1'b0);
      if (!rst_n) begin
        bitn = 0;
        slave_low = 1'b0;
      end else if (scl_p && scl && sda_p && !sda) begin
        started = 1'b1; stopped = 1'b0; bitn = 0; scl_rises = 0; fb.delete();
      end else if (scl_p && scl && !sda_p && sda) begin
        stopped = 1'b1; bitn = 0;
      end else if (!scl_p && scl) begin
        scl_rises++;
        if (bitn < 8) begin
          cur = {cur[6:0], sda};
          bitn++;
        end else begin
          fb.push_back(cur);
          bitn = 0;
        end
      end else if (scl_p && !scl) begin
        slave_low = (bitn == 8) && !(nack_addr && fb.size() == 0);
      end
      scl_p = scl;
      sda_p = sda;
    end
  end

  // Scoreboard monitor: every done pulse pops one expected frame.
  initial begin
    exp_t e;
    int   t_launch, nb;
    bit   busy_p, after_done;
    busy_p = 1'b0; after_done = 1'b0; t_launch = 0;
    forever begin
      @(negedge clk);
      if (after_done) begin
        check("done_one_cycle", int'(done), 0);
        check("busy_falls_with_done", int'(busy), 0);
        after_done = 1'b0;
      end
      if (rst_n && busy && !busy_p) t_launch = cyc;
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", done_cnt, -1);
        end else begin
          e  = sb.pop_front();
          nb = e.nack ? 1 : 3;
          check("frame_start_seen", int'(started), 1);
          check("frame_stop_seen", int'(stopped), 1);
          check("byte_count", fb.size(), nb);
          if (fb.size() >= 1) check("byte0_addr", int'(fb[0]), 'h34);
          if (nb == 3 && fb.size() == 3) begin
            check("byte1_reg", int'(fb[1]), 'h05);
            check("byte2_vol", int'(fb[2]), int'(e.vol));
          end
          check("scl_rises", scl_rises, e.nack ? 10 : 28);
          check("nack_err_at_done", int'(nack_err), int'(e.nack));
          check("frame_clocks", cyc - t_launch, (e.nack ? 44 : 116) * CLK_DIV);
        end
        started = 1'b0;
        done_cnt++;
        after_done = 1'b1;
      end
      busy_p = busy;
    end
  end

  task automatic pulse(input logic [6:0] v);
    @(negedge clk);
    volume = v; vol_update = 1'b1;
    @(negedge clk);
    vol_update = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int bound);
    int k;
    k = 0;
    while (done_cnt < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("frames_done", done_cnt, target);
  endtask

  task automatic idle_bus_check(input string tag);
    check({tag, "_sclk"}, int'(i2c_sclk), 1);
    check({tag, "_sda_released"}, int'(sda_line === 1'b1), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    idle_bus_check("reset");
    check("reset_nack_err", int'(nack_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic ACKed write with launch latency.
    sb.push_back('{7'h79, 1'b0});
    pulse(7'h79);
    check("launch_busy_n", int'(busy), 0);
    @(negedge clk);
    check("launch_busy_n1", int'(busy), 1);
    check("start_q0_sclk", int'(i2c_sclk), 1);
    check("start_q0_sda", int'(sda_line === 1'b1), 1);
    wait_frames(1, 400);
    check("nack_err_after_ok", int'(nack_err), 0);

    // NACK on the address byte.
    nack_addr = 1'b1;
    sb.push_back('{7'h11, 1'b1});
    pulse(7'h11);
    wait_frames(2, 400);
    nack_addr = 1'b0;
    repeat (4) @(negedge clk);
    check("nack_err_sticky", int'(nack_err), 1);

    // Successful write clears the sticky flag.
    sb.push_back('{7'h2F, 1'b0});
    pulse(7'h2F);
    wait_frames(3, 400);
    check("nack_err_cleared", int'(nack_err), 0);

    // Coalescing: three requests during one transfer -> one follow-up frame.
    sb.push_back('{7'h40, 1'b0});
    sb.push_back('{7'h60, 1'b0});
    pulse(7'h40);
    repeat (20) @(negedge clk);
    pulse(7'h30);
    repeat (20) @(negedge clk);
    pulse(7'h50);
    repeat (20) @(negedge clk);
    pulse(7'h60);
    wait_frames(5, 1000);
    repeat (20) @(negedge clk);
    check("coalesce_two_frames", done_cnt, 5);
    check("coalesce_idle", int'(busy), 0);

    // Request in the same cycle as done.
    sb.push_back('{7'h21, 1'b0});
    sb.push_back('{7'h55, 1'b0});
    pulse(7'h21);
    k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", int'(done), 1);
    volume = 7'h55; vol_update = 1'b1;
    @(negedge clk);
    vol_update = 1'b0;
    check("same_cycle_idle_gap", int'(busy), 0);
    @(negedge clk);
    check("same_cycle_relaunch", int'(busy), 1);
    wait_frames(7, 600);

    // Reset in the middle of byte1 (bit3 of 0x05, SDA driven low).
    repeat (4) @(negedge clk);
    pulse(7'h33);
    @(negedge clk);
    repeat (106) @(negedge clk);
    check("midframe_sclk_low", int'(i2c_sclk), 0);
    check("midframe_sda_low", int'(sda_line === 1'b0), 1);
    rst_n = 1'b0;
    @(negedge clk);
    idle_bus_check("abort");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clean frame after the abort.
    sb.push_back('{7'h2A, 1'b0});
    pulse(7'h2A);
    wait_frames(8, 400);
    repeat (4) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
